// File: rtl/accum_group_arbiter_pkg.sv
// ------------------------------------------------------------------
// accum_arb_pkg : shared state type, default sizes, id-width helper
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package accum_arb_pkg;

  localparam int c_DEF_WIDTH     = 32;
  localparam int c_DEF_NUM_REQ   = 4;
  localparam int c_DEF_TAG_DEPTH = 16;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Never returns less than 1 so single-entry vectors still have a bit.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/accum_group_arbiter_if.sv
// ------------------------------------------------------------------
// accum_group_arbiter_if : requester, accumulator and result bundle
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface accum_group_arbiter_if
  import accum_arb_pkg::*;
#(
  parameter int WIDTH   = c_DEF_WIDTH,
  parameter int NUM_REQ = c_DEF_NUM_REQ
);
  localparam int ID_W = clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_ip;
  logic [NUM_REQ-1:0]            req_end_of_group;
  logic [NUM_REQ-1:0]            req_ready;

  logic                          acc_valid_in;
  logic [WIDTH-1:0]              acc_ip;
  logic                          acc_end_of_group;
  logic                          acc_ready;
  logic                          acc_valid_out;
  logic [WIDTH-1:0]              acc_result;

  logic                          out_valid;
  logic [WIDTH-1:0]              out_result;
  logic [ID_W-1:0]               out_id;
  logic                          tag_underflow;

  modport master (
    output req_valid, req_ip, req_end_of_group, acc_ready, acc_valid_out, acc_result,
    input  req_ready, acc_valid_in, acc_ip, acc_end_of_group,
    input  out_valid, out_result, out_id, tag_underflow
  );

  modport slave (
    input  req_valid, req_ip, req_end_of_group, acc_ready, acc_valid_out, acc_result,
    output req_ready, acc_valid_in, acc_ip, acc_end_of_group,
    output out_valid, out_result, out_id, tag_underflow
  );

endinterface

`default_nettype wire

// File: rtl/accum_tag_fifo.sv
// ------------------------------------------------------------------
// accum_tag_fifo : zero-latency FIFO of group-owner ids
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module accum_tag_fifo
  import accum_arb_pkg::*;
#(
  parameter int DEPTH = c_DEF_TAG_DEPTH,
  parameter int ID_W  = 2
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            i_push,
  input  wire logic [ID_W-1:0] i_push_id,
  input  wire logic            i_pop,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [ID_W-1:0]      o_head
);
  localparam int PTR_W = clog2(DEPTH);

  logic [ID_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];
  // A pop on a full FIFO frees the slot the same-edge push lands in.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH-1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH-1)) ? '0 : r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/accum_group_arbiter.sv
// ------------------------------------------------------------------
// accum_group_arbiter : group-granular round-robin share of one accumulator
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module accum_group_arbiter
  import accum_arb_pkg::*;
#(
  parameter int WIDTH     = c_DEF_WIDTH,
  parameter int NUM_REQ   = c_DEF_NUM_REQ,
  parameter int TAG_DEPTH = c_DEF_TAG_DEPTH
) (
  input wire logic              clk,
  input wire logic              rst,
  accum_group_arbiter_if.slave  arb_bus
);
  localparam int ID_W = clog2(NUM_REQ);

  arb_state_t       r_state;
  logic [ID_W-1:0]  r_owner;
  logic [ID_W-1:0]  r_last_owner;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_result;
  logic [ID_W-1:0]  r_out_id;
  logic             r_underflow;

  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [ID_W-1:0]  w_fifo_head;
  logic             w_any_valid;
  logic [ID_W-1:0]  w_rr_pick;
  logic [ID_W-1:0]  w_cand;
  logic             w_grant;
  logic             w_locked;
  logic             w_group_done;

  // Descending scan so the candidate nearest last_owner+1 wins.
  always_comb begin
    w_any_valid = 1'b0;
    w_rr_pick   = r_last_owner;
    w_cand      = r_last_owner;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = ID_W'((int'(r_last_owner) + k) % NUM_REQ);
      if (arb_bus.req_valid[w_cand]) begin
        w_rr_pick   = w_cand;
        w_any_valid = 1'b1;
      end
    end
  end

  assign w_grant      = (r_state == IDLE) && w_any_valid && !w_fifo_full;
  assign w_locked     = (r_state == LOCKED) && !rst;
  assign w_group_done = arb_bus.acc_valid_in && arb_bus.acc_ready && arb_bus.acc_end_of_group;

  assign arb_bus.acc_valid_in     = w_locked && arb_bus.req_valid[r_owner];
  assign arb_bus.acc_ip           = arb_bus.req_ip[r_owner];
  assign arb_bus.acc_end_of_group = w_locked && arb_bus.req_end_of_group[r_owner];

  always_comb begin
    arb_bus.req_ready = '0;
    if (w_locked) arb_bus.req_ready[r_owner] = arb_bus.acc_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_owner      <= '0;
      r_last_owner <= ID_W'(NUM_REQ - 1);
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_id     <= '0;
      r_underflow  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_state <= LOCKED;
            r_owner <= w_rr_pick;
          end
        end
        LOCKED: begin
          if (w_group_done) begin
            r_state      <= IDLE;
            r_last_owner <= r_owner;
          end
        end
        default: r_state <= IDLE;
      endcase

      r_out_valid <= arb_bus.acc_valid_out;
      if (arb_bus.acc_valid_out) begin
        r_out_result <= arb_bus.acc_result;
        r_out_id     <= w_fifo_empty ? '0 : w_fifo_head;
        if (w_fifo_empty) r_underflow <= 1'b1;
      end
    end
  end

  assign arb_bus.out_valid     = r_out_valid;
  assign arb_bus.out_result    = r_out_result;
  assign arb_bus.out_id        = r_out_id;
  assign arb_bus.tag_underflow = r_underflow;

  accum_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .ID_W  (ID_W)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_grant),
    .i_push_id (w_rr_pick),
    .i_pop     (arb_bus.acc_valid_out),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_head    (w_fifo_head)
  );

endmodule

`default_nettype wire
